// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared state encoding, master indices and widths for the
//                two-master bridge arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam int M_CPU = 0;
    localparam int M_DMA = 1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t own_state(input logic is_dma);
        return is_dma ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_if
//  Description : Both master request channels plus the shared bridge port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_we;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_lock;
    logic              m0_gnt;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_we;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_lock;
    logic              m1_gnt;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    // Arbiter side
    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wdata, m0_lock,
        input  m1_req, m1_addr, m1_we, m1_wdata, m1_lock,
        input  bus_rdata,
        output m0_gnt, m0_rdata, m1_gnt, m1_rdata,
        output bus_addr, bus_we, bus_wdata
    );

    // Masters plus bridge side
    modport master (
        output m0_req, m0_addr, m0_we, m0_wdata, m0_lock,
        output m1_req, m1_addr, m1_we, m1_wdata, m1_lock,
        output bus_rdata,
        input  m0_gnt, m0_rdata, m1_gnt, m1_rdata,
        input  bus_addr, bus_we, bus_wdata
    );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_sat_counter
//  Description : Up-counter that saturates at LIMIT; clear wins over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_inc,
    input  wire              i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != C_LIMIT)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : CPU-priority arbiter for the bridge data port with a
//                starvation guard for master 1 and bounded bus locking.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_LOCK     = 8,
    parameter int CNT_W        = 4
) (
    input  wire          arb_clk,
    input  wire          arb_rst,
    bus_arbiter_if.slave arb
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [CNT_W-1:0] w_starve_cnt;
    logic [CNT_W-1:0] w_lock_cnt;
    logic [1:0]       w_gnt;
    logic             w_starve_force;
    logic             w_lock_req;
    logic             w_lock_ok;
    logic             w_lock_take;

    // A locked owner that drops req falls straight into IDLE rules this cycle.
    always_comb begin
        w_starve_force = arb.m1_req && (w_starve_cnt == CNT_W'(STARVE_LIMIT));
        w_gnt          = 2'b00;
        if (!arb_rst) begin
            if ((r_state == ARB_OWN0) && arb.m0_req) begin
                w_gnt[M_CPU] = 1'b1;
            end else if ((r_state == ARB_OWN1) && arb.m1_req) begin
                w_gnt[M_DMA] = 1'b1;
            end else if (w_starve_force) begin
                w_gnt[M_DMA] = 1'b1;
            end else if (arb.m0_req) begin
                w_gnt[M_CPU] = 1'b1;
            end else if (arb.m1_req) begin
                w_gnt[M_DMA] = 1'b1;
            end
        end
    end

    always_comb begin
        w_lock_req   = w_gnt[M_DMA] ? arb.m1_lock : arb.m0_lock;
        w_lock_ok    = (32'(w_lock_cnt) + 32'd1) < 32'(MAX_LOCK);
        w_lock_take  = (|w_gnt) && w_lock_req && w_lock_ok;
        w_next_state = ARB_IDLE;
        if (w_lock_take) begin
            w_next_state = own_state(w_gnt[M_DMA]);
        end
    end

    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    arb_sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (arb_clk),
        .rst     (arb_rst),
        .i_inc   (arb.m1_req && !w_gnt[M_DMA]),
        .i_clr   (w_gnt[M_DMA] || !arb.m1_req),
        .o_count (w_starve_cnt)
    );

    // Every cycle that does not extend a lock returns to IDLE, so it clears.
    arb_sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (MAX_LOCK)
    ) u_lock_cnt (
        .clk     (arb_clk),
        .rst     (arb_rst),
        .i_inc   (w_lock_take),
        .i_clr   (!w_lock_take),
        .o_count (w_lock_cnt)
    );

    assign arb.m0_gnt    = w_gnt[M_CPU];
    assign arb.m1_gnt    = w_gnt[M_DMA];

    assign arb.bus_addr  = w_gnt[M_DMA] ? arb.m1_addr  :
                           w_gnt[M_CPU] ? arb.m0_addr  : '0;
    assign arb.bus_wdata = w_gnt[M_DMA] ? arb.m1_wdata :
                           w_gnt[M_CPU] ? arb.m0_wdata : '0;
    assign arb.bus_we    = w_gnt[M_DMA] ? arb.m1_we    :
                           w_gnt[M_CPU] ? arb.m0_we    : 1'b0;

    assign arb.m0_rdata  = w_gnt[M_CPU] ? arb.bus_rdata : '0;
    assign arb.m1_rdata  = w_gnt[M_DMA] ? arb.bus_rdata : '0;

endmodule
`default_nettype wire
